// File: rtl/csr_rmw_legalizer_if.sv
// Request/response and CSR-file bus for csr_rmw_legalizer.
// The master side is the pipeline plus CSR file; the slave side is the legalizer.
interface csr_rmw_legalizer_if #(
    parameter int W = 64
);
    logic         i_req_valid;
    logic         o_req_ready;
    logic [2:0]   i_funct3;
    logic [11:0]  i_csr_addr;
    logic [W-1:0] i_src;
    logic         i_src_nz;
    logic         i_flush;
    logic [11:0]  o_csr_rd_addr;
    logic [W-1:0] i_csr_rd_data;
    logic         o_csr_we;
    logic [11:0]  o_csr_wr_addr;
    logic [W-1:0] o_csr_wr_data;
    logic         o_rsp_valid;
    logic         i_rsp_ready;
    logic [W-1:0] o_rsp_rdata;
    logic         o_rsp_illegal;
    logic [31:0]  o_write_count;

    modport master (
        output i_req_valid, i_funct3, i_csr_addr, i_src, i_src_nz, i_flush,
               i_csr_rd_data, i_rsp_ready,
        input  o_req_ready, o_csr_rd_addr, o_csr_we, o_csr_wr_addr, o_csr_wr_data,
               o_rsp_valid, o_rsp_rdata, o_rsp_illegal, o_write_count
    );

    modport slave (
        input  i_req_valid, i_funct3, i_csr_addr, i_src, i_src_nz, i_flush,
               i_csr_rd_data, i_rsp_ready,
        output o_req_ready, o_csr_rd_addr, o_csr_we, o_csr_wr_addr, o_csr_wr_data,
               o_rsp_valid, o_rsp_rdata, o_rsp_illegal, o_write_count
    );
endinterface

// File: rtl/csr_rmw_legalizer.sv
// Zicsr read-modify-write sequencer with WARL/WPRI legalization (IDLE/READ/WRITE/RESP).
// Optional completed-write counter enabled by defining CSR_WRITE_COUNTER_EN.
module csr_rmw_legalizer #(
    parameter logic [1:0]  XLEN                 = 2'b10,
    parameter int          PMP_COUNT            = 16,
    parameter logic [25:0] SUPPORTED_EXTENSIONS = 26'h0000100
) (
    input  logic               i_clk,
    input  logic               i_rst,
    csr_rmw_legalizer_if.slave bus
);
    localparam int W = 1 << (int'(XLEN) + 4);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;
    localparam logic [1:0] RESP  = 2'b11;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSTATUSH = 12'h310;
    localparam logic [11:0] CSR_MENVCFGH = 12'h31A;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MSECCFGH = 12'h757;

    // Set bits take the new value, clear bits preserve the old (WPRI) value.
    localparam logic [W-1:0] MSTATUS_WMASK  = (W == 64) ? W'(64'h8000_07FF_01FF_FFFE)
                                                        : W'(64'h0000_0000_81FF_FFFE);
    localparam logic [W-1:0] MSTATUSH_WMASK = W'(64'h0000_0000_0000_07F0);

    function automatic logic is_pmpaddr(input logic [11:0] addr);
        return addr[11:4] == 8'h3B;
    endfunction

    function automatic logic pmp_unimpl(input logic [11:0] addr);
        return is_pmpaddr(addr) && (int'(addr[3:0]) >= PMP_COUNT);
    endfunction

    function automatic logic is_high_half(input logic [11:0] addr);
        return (addr == CSR_MSTATUSH) || (addr == CSR_MENVCFGH) || (addr == CSR_MSECCFGH);
    endfunction

    function automatic logic [W-1:0] read_legalize(input logic [11:0] addr,
                                                   input logic [W-1:0] d);
        logic [W-1:0] r;
        r = d;
        if (addr == CSR_MISA) begin
            r = '0;
            r[W-1:W-2] = (d[W-1:W-2] == 2'b01 || d[W-1:W-2] == 2'b10) ? d[W-1:W-2] : 2'b01;
            r[25:0] = d[25:0] & SUPPORTED_EXTENSIONS;
        end else if (addr == CSR_MTVEC) begin
            if (d[1]) r[1:0] = 2'b00;
        end else if (addr == CSR_MCAUSE) begin
            if (!((~|d[W-2:4]) && (d[3:0] inside {4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd11})))
                r[W-2:0] = '0;
        end else if (is_high_half(addr)) begin
            if (W == 64) r = '0;
        end else if (pmp_unimpl(addr)) begin
            r = '0;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] write_legalize(input logic [11:0] addr,
                                                    input logic [W-1:0] nv,
                                                    input logic [W-1:0] old);
        logic [W-1:0] r;
        r = nv;
        if (addr == CSR_MSTATUS) begin
            r = (nv & MSTATUS_WMASK) | (old & ~MSTATUS_WMASK);
        end else if (addr == CSR_MSTATUSH) begin
            if (W == 32) r = (nv & MSTATUSH_WMASK) | (old & ~MSTATUSH_WMASK);
        end else if (addr == CSR_MTVEC) begin
            if (nv[1]) r[1:0] = 2'b00;
        end else if (is_pmpaddr(addr)) begin
            r[1:0] = old[1:0];
        end
        return r;
    endfunction

    // Writes silently dropped without flagging the access illegal.
    function automatic logic write_blocked(input logic [11:0] addr);
        return (addr == CSR_MISA) || (is_high_half(addr) && W == 64) || pmp_unimpl(addr);
    endfunction

    logic [1:0]   state;
    logic [2:0]   funct3_r;
    logic [11:0]  addr_r;
    logic [W-1:0] src_r;
    logic         src_nz_r;
    logic         we_ok_r;
    logic         illegal_r;
    logic [W-1:0] wr_data_r;
    logic [11:0]  wr_addr_r;
    logic [W-1:0] rsp_rdata_r;

    logic [W-1:0] old_legal;
    logic [W-1:0] new_raw;
    logic         wen;
    logic         illegal;
    logic         accept;
    logic         csr_we;

    always_comb begin
        old_legal = read_legalize(addr_r, bus.i_csr_rd_data);
        case (funct3_r[1:0])
            2'b10:   new_raw = old_legal | src_r;
            2'b11:   new_raw = old_legal & ~src_r;
            default: new_raw = src_r;
        endcase
        wen     = (funct3_r[1:0] == 2'b01) ? 1'b1 : src_nz_r;
        illegal = (funct3_r == 3'b000) || (funct3_r == 3'b100) ||
                  (wen && addr_r[11:10] == 2'b11);
    end

    assign accept = (state == IDLE) && bus.i_req_valid && !bus.i_flush;
    // Gated by reset so a reset landing on WRITE never reaches the CSR file.
    assign csr_we = (state == WRITE) && we_ok_r && !i_rst;

    // Request capture stage (data only, no reset needed)
    always_ff @(posedge i_clk) begin
        if (accept) begin
            funct3_r <= bus.i_funct3;
            src_r    <= bus.i_src;
            src_nz_r <= bus.i_src_nz;
        end
    end

    // Sequencer and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            addr_r      <= '0;
            we_ok_r     <= 1'b0;
            illegal_r   <= 1'b0;
            wr_data_r   <= '0;
            wr_addr_r   <= '0;
            rsp_rdata_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_r <= bus.i_csr_addr;
                        state  <= READ;
                    end
                end
                READ: begin
                    if (bus.i_flush) begin
                        state <= IDLE;
                    end else begin
                        we_ok_r     <= wen && !illegal && !write_blocked(addr_r);
                        illegal_r   <= illegal;
                        wr_data_r   <= write_legalize(addr_r, new_raw, bus.i_csr_rd_data);
                        wr_addr_r   <= addr_r;
                        rsp_rdata_r <= illegal ? '0 : old_legal;
                        state       <= WRITE;
                    end
                end
                WRITE: state <= RESP;
                RESP: begin
                    if (bus.i_rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_req_ready   = (state == IDLE) && !bus.i_flush;
    assign bus.o_csr_rd_addr = addr_r;
    assign bus.o_csr_we      = csr_we;
    assign bus.o_csr_wr_addr = wr_addr_r;
    assign bus.o_csr_wr_data = wr_data_r;
    assign bus.o_rsp_valid   = (state == RESP);
    assign bus.o_rsp_rdata   = rsp_rdata_r;
    assign bus.o_rsp_illegal = illegal_r;

`ifdef CSR_WRITE_COUNTER_EN
    logic [31:0] write_count_r;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            write_count_r <= '0;
        end else if (csr_we && write_count_r != 32'hFFFF_FFFF) begin
            write_count_r <= write_count_r + 32'd1;
        end
    end

    assign bus.o_write_count = write_count_r;
`else
    assign bus.o_write_count = 32'd0;
`endif
endmodule

// File: tb/tb_csr_rmw_legalizer.sv
// Scoreboard bench for csr_rmw_legalizer at XLEN=64, PMP_COUNT=16, misa = I only.
module tb_csr_rmw_legalizer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    csr_rmw_legalizer_if #(.W(64)) bus ();

    csr_rmw_legalizer #(
        .XLEN                 (2'b10),
        .PMP_COUNT            (16),
        .SUPPORTED_EXTENSIONS (26'h0000100)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [11:0] addr;
        logic [63:0] data;
    } wr_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        illegal;
    } rsp_t;

    wr_t  wq[$];
    rsp_t rq[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every write strobe and response handshake consumes one expectation.
    always @(negedge clk) begin
        wr_t  w;
        rsp_t r;
        if (!rst) begin
            if (bus.o_csr_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_we", 64'd1, 64'd0);
                end else begin
                    w = wq.pop_front();
                    check("sb_wr_addr", 64'(bus.o_csr_wr_addr), 64'(w.addr));
                    check("sb_wr_data", bus.o_csr_wr_data, w.data);
                end
            end
            if (bus.o_rsp_valid && bus.i_rsp_ready) begin
                if (rq.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    r = rq.pop_front();
                    check("sb_rsp_rdata", bus.o_rsp_rdata, r.rdata);
                    check("sb_rsp_illegal", 64'(bus.o_rsp_illegal), 64'(r.illegal));
                end
            end
        end
    end

    // Enters and leaves one clock after a rising edge with the DUT in IDLE.
    task automatic run_txn(input string name, input logic [2:0] f3, input logic [11:0] addr,
                           input logic [63:0] src, input logic nz, input logic [63:0] old,
                           input logic exp_we, input logic [63:0] exp_wdata,
                           input logic [63:0] exp_rdata, input logic exp_ill, input int hold);
        if (exp_we) wq.push_back({addr, exp_wdata});
        rq.push_back({exp_rdata, exp_ill});
        bus.i_req_valid   = 1'b1;
        bus.i_funct3      = f3;
        bus.i_csr_addr    = addr;
        bus.i_src         = src;
        bus.i_src_nz      = nz;
        bus.i_csr_rd_data = old;
        bus.i_rsp_ready   = (hold == 0);
        @(negedge clk);
        check({name, "_req_ready"}, 64'(bus.o_req_ready), 64'd1);
        tick();
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        check({name, "_rd_addr"}, 64'(bus.o_csr_rd_addr), 64'(addr));
        check({name, "_we_read"}, 64'(bus.o_csr_we), 64'd0);
        tick();
        @(negedge clk);
        check({name, "_we_cycle2"}, 64'(bus.o_csr_we), 64'(exp_we));
        tick();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, 64'(bus.o_rsp_valid), 64'd1);
            check({name, "_hold_rdata"}, bus.o_rsp_rdata, exp_rdata);
            check({name, "_hold_illegal"}, 64'(bus.o_rsp_illegal), 64'(exp_ill));
            check({name, "_hold_req_ready"}, 64'(bus.o_req_ready), 64'd0);
            tick();
        end
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        check({name, "_rsp_valid"}, 64'(bus.o_rsp_valid), 64'd1);
        tick();
        @(negedge clk);
        check({name, "_idle_rsp_valid"}, 64'(bus.o_rsp_valid), 64'd0);
        check({name, "_idle_req_ready"}, 64'(bus.o_req_ready), 64'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_count;
        bus.i_req_valid   = 1'b0;
        bus.i_funct3      = 3'b000;
        bus.i_csr_addr    = 12'h000;
        bus.i_src         = 64'd0;
        bus.i_src_nz      = 1'b0;
        bus.i_flush       = 1'b0;
        bus.i_csr_rd_data = 64'd0;
        bus.i_rsp_ready   = 1'b1;

        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_csr_we", 64'(bus.o_csr_we), 64'd0);
        check("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        check("rst_rsp_illegal", 64'(bus.o_rsp_illegal), 64'd0);
        check("rst_rsp_rdata", bus.o_rsp_rdata, 64'd0);
        check("rst_wr_data", bus.o_csr_wr_data, 64'd0);
        check("rst_wr_addr", 64'(bus.o_csr_wr_addr), 64'd0);
        check("rst_rd_addr", 64'(bus.o_csr_rd_addr), 64'd0);
        check("rst_write_count", 64'(bus.o_write_count), 64'd0);
        rst = 1'b0;
        tick();

        run_txn("rw_mstatus", 3'b001, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0,
                1'b1, 64'h8000_07FF_01FF_FFFE, 64'd0, 1'b0, 0);
        run_txn("rs_mcause_keep", 3'b010, 12'h342, 64'd0, 1'b0, 64'h7,
                1'b0, 64'd0, 64'h7, 1'b0, 0);
        run_txn("rs_mcause_drop", 3'b010, 12'h342, 64'd0, 1'b0, 64'h9,
                1'b0, 64'd0, 64'd0, 1'b0, 0);
        run_txn("rw_cycle_ro", 3'b001, 12'hC00, 64'h5, 1'b1, 64'h1234,
                1'b0, 64'd0, 64'd0, 1'b1, 0);
        run_txn("funct3_100", 3'b100, 12'h340, 64'h5, 1'b1, 64'h1234,
                1'b0, 64'd0, 64'd0, 1'b1, 0);
        run_txn("rc_mtvec", 3'b011, 12'h305, 64'h1, 1'b1, 64'h1001,
                1'b1, 64'h1000, 64'h1001, 1'b0, 5);
        run_txn("rw_mtvec_mode", 3'b001, 12'h305, 64'h2003, 1'b1, 64'h1000,
                1'b1, 64'h2000, 64'h1000, 1'b0, 0);
        run_txn("rw_misa", 3'b001, 12'h301, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'h8000_0100_0014_1105, 1'b0, 64'd0, 64'h8000_0000_0000_0100, 1'b0, 0);
        run_txn("csrr_cycle", 3'b010, 12'hC00, 64'd0, 1'b0, 64'h55,
                1'b0, 64'd0, 64'h55, 1'b0, 0);
        run_txn("rw_mstatush64", 3'b001, 12'h310, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFF,
                1'b0, 64'd0, 64'd0, 1'b0, 0);

        // Flush in IDLE blocks acceptance.
        bus.i_req_valid = 1'b1;
        bus.i_funct3    = 3'b001;
        bus.i_csr_addr  = 12'h340;
        bus.i_src       = 64'h77;
        bus.i_src_nz    = 1'b1;
        bus.i_flush     = 1'b1;
        @(negedge clk);
        check("flush_idle_ready", 64'(bus.o_req_ready), 64'd0);
        tick();
        bus.i_req_valid = 1'b0;
        bus.i_flush     = 1'b0;
        @(negedge clk);
        check("flush_idle_stays", 64'(bus.o_req_ready), 64'd1);
        check("flush_idle_rd_addr", 64'(bus.o_csr_rd_addr), 64'h310);

        // Flush during READ abandons the access.
        bus.i_req_valid = 1'b1;
        tick();
        bus.i_req_valid = 1'b0;
        bus.i_flush     = 1'b1;
        @(negedge clk);
        check("flush_read_we", 64'(bus.o_csr_we), 64'd0);
        tick();
        bus.i_flush = 1'b0;
        @(negedge clk);
        check("flush_read_ready", 64'(bus.o_req_ready), 64'd1);
        check("flush_read_rsp", 64'(bus.o_rsp_valid), 64'd0);
        check("flush_read_we2", 64'(bus.o_csr_we), 64'd0);
        tick();

        // Reset landing on WRITE suppresses the strobe and returns to IDLE.
        bus.i_req_valid   = 1'b1;
        bus.i_funct3      = 3'b001;
        bus.i_csr_addr    = 12'h300;
        bus.i_src         = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.i_src_nz      = 1'b1;
        bus.i_csr_rd_data = 64'd0;
        tick();
        bus.i_req_valid = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_write_we", 64'(bus.o_csr_we), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_write_ready", 64'(bus.o_req_ready), 64'd1);
        check("rst_write_rsp", 64'(bus.o_rsp_valid), 64'd0);
        check("rst_write_wdata", bus.o_csr_wr_data, 64'd0);
        check("rst_write_rdata", bus.o_rsp_rdata, 64'd0);
        check("rst_write_count", 64'(bus.o_write_count), 64'd0);
        tick();

        run_txn("rw_pmpaddr3", 3'b001, 12'h3B3, 64'hFFFF, 1'b1, 64'h2,
                1'b1, 64'hFFFE, 64'h2, 1'b0, 0);
        run_txn("rsi_mscratch", 3'b110, 12'h340, 64'h10, 1'b1, 64'h1,
                1'b1, 64'h11, 64'h1, 1'b0, 0);
        run_txn("rw_mcause_int", 3'b001, 12'h342, 64'h8000_0000_0000_0003, 1'b1,
                64'h8000_0000_0000_0005, 1'b1, 64'h8000_0000_0000_0003,
                64'h8000_0000_0000_0005, 1'b0, 0);

`ifdef CSR_WRITE_COUNTER_EN
        exp_count = 32'd3;
`else
        exp_count = 32'd0;
`endif
        @(negedge clk);
        check("write_count", 64'(bus.o_write_count), 64'(exp_count));
        check("wq_drained", 64'(wq.size()), 64'd0);
        check("rq_drained", 64'(rq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
